// File: rtl/clksel_pkg.sv
// Shared definitions for the CPU clock-select scheduler: state encoding
// and the default select-acknowledge timeout.
package clksel_pkg;

  typedef enum logic [1:0] {
    FAST    = 2'b00,
    TO_SLOW = 2'b01,
    SLOW    = 2'b10,
    TO_FAST = 2'b11
  } clksel_state_e;

  localparam int TMO_CYC_DEF = 64;

endpackage

// File: rtl/clksel_timer.sv
// Saturating counters for the clock-select scheduler: the handover
// timeout timer (saturates at TMO_CYC-1) and the slow-mode holdoff
// down-counter (saturates at 0, resets to all-ones).
module clksel_timer
  import clksel_pkg::*;
#(
  parameter int HOLD_W  = 4,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              timer_clr,
  input  logic              timer_inc,
  input  logic              hold_load,
  input  logic              hold_dec,
  input  logic [HOLD_W-1:0] hold_val,
  output logic              timer_max,
  output logic              hold_zero
);

  localparam int TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign timer_max = (timer_q == TMO_LAST);
  assign hold_zero = (hold_q == '0);

  // Next-value logic: clear/load take priority over counting; both saturate.
  always_comb begin
    timer_d = timer_q;
    hold_d  = hold_q;
    if (timer_clr) begin
      timer_d = '0;
    end else if (timer_inc && !timer_max) begin
      timer_d = timer_q + TMO_W'(1);
    end
    if (hold_load) begin
      hold_d = hold_val;
    end else if (hold_dec && !hold_zero) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  // Counter registers; holdoff starts at all-ones so the first exit from
  // SLOW after reset waits the longest possible holdoff.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      timer_q <= '0;
      hold_q  <= '1;
    end else begin
      timer_q <= timer_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/clksel_sched.sv
// CPU clock-select scheduler: moves the CPU clock mux between the fast and
// slow sources, switching hienable only at a safe clock phase and watching
// the retimed select acknowledges for timeouts and contradictions.
// Build option: CLKSEL_STOP_IN_PHI1_EN hands over with clocks stopped low
// (phase_in == 0); otherwise handover happens with clocks stopped high.
module clksel_sched
  import clksel_pkg::*;
#(
  parameter int HOLD_W  = 4,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              phase_in,
  input  logic              slow_req,
  input  logic              lo_sel,
  input  logic              hi_sel,
  input  logic [HOLD_W-1:0] holdoff_cfg,
  input  logic              err_clr,
  output logic              hienable,
  output logic              fast,
  output logic              busy,
  output logic              err
);

  clksel_state_e state_q, state_d;
  logic hienable_q, hienable_d;
  logic err_q, err_d, err_set;
  logic fast_q, fast_d;
  logic busy_q, busy_d;
  logic phase_ok, both_sel;
  logic timer_clr, timer_inc, hold_load, hold_dec;
  logic timer_max, hold_zero;

`ifdef CLKSEL_STOP_IN_PHI1_EN
  assign phase_ok = (phase_in == 1'b0);
`else
  assign phase_ok = (phase_in == 1'b1);
`endif

  assign both_sel = lo_sel & hi_sel;

  clksel_timer #(
    .HOLD_W  (HOLD_W),
    .TMO_CYC (TMO_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_b     (rst_b),
    .timer_clr (timer_clr),
    .timer_inc (timer_inc),
    .hold_load (hold_load),
    .hold_dec  (hold_dec),
    .hold_val  (holdoff_cfg),
    .timer_max (timer_max),
    .hold_zero (hold_zero)
  );

  // Next-state, hienable and counter control; contradictory acknowledges
  // freeze every transition for the cycle and raise err.
  always_comb begin
    state_d    = state_q;
    hienable_d = hienable_q;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    err_set    = both_sel;
    case (state_q)
      FAST: begin
        if (slow_req && phase_ok && !both_sel) begin
          hienable_d = 1'b0;
          timer_clr  = 1'b1;
          state_d    = TO_SLOW;
        end
      end
      TO_SLOW: begin
        err_set = err_set | timer_max;
        if (lo_sel && !hi_sel) begin
          hold_load = 1'b1;
          state_d   = SLOW;
        end else begin
          timer_inc = 1'b1;
        end
      end
      SLOW: begin
        hold_dec = 1'b1;
        if (hold_zero && !slow_req && phase_ok && !both_sel) begin
          hienable_d = 1'b1;
          timer_clr  = 1'b1;
          state_d    = TO_FAST;
        end
      end
      TO_FAST: begin
        err_set = err_set | timer_max;
        if (hi_sel && !lo_sel) begin
          state_d = FAST;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: begin
        state_d = SLOW;
      end
    endcase
    err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    fast_d = (state_d == FAST);
    busy_d = (state_d == TO_SLOW) || (state_d == TO_FAST);
  end

  // State and output registers; fast/busy are decoded from the next state
  // so they are flops that always agree with the registered state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= SLOW;
      hienable_q <= 1'b0;
      err_q      <= 1'b0;
      fast_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hienable_q <= hienable_d;
      err_q      <= err_d;
      fast_q     <= fast_d;
      busy_q     <= busy_d;
    end
  end

  assign hienable = hienable_q;
  assign fast     = fast_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
